ram_program_loader: RTL and testbench

//  Boot-time controller that sequences the memory address register and RAM to load
//  a program from a byte stream (UART receiver / host) into the 16-entry RAM.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/ram_program_loader.sv | 120 ++++++++++++
 tb/tb_ram_program_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: loader state encoding and default widths.
// Imported by the program loader and its neighbours on the shared bus.
package cpu_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t IDLE      = 3'd0;
  localparam loader_state_t WAIT_BYTE = 3'd1;
  localparam loader_state_t ADDR      = 3'd2;
  localparam loader_state_t DATA      = 3'd3;
  localparam loader_state_t DONE      = 3'd4;

endpackage

// File: rtl/ram_program_loader.sv
// Boot loader: streams bytes into RAM via MAR load / RAM write.
// Holds the CPU halted and owns the shared bus while loading.
module ram_program_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  manual_mode,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_drive,
  output logic                  mar_load,
  output logic                  ram_write,
  output logic                  cpu_halt,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   bytes_loaded
);

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  loader_state_t         state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] bus_val;

  // State, address counter, captured byte and byte count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      data_q       <= '0;
      bytes_loaded <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (start && !manual_mode) begin
            state        <= WAIT_BYTE;
            addr         <= '0;
            bytes_loaded <= '0;
          end
        end
        (state == WAIT_BYTE): begin
          if (in_valid) begin
            data_q <= in_data;
            state  <= ADDR;
          end else if (finish) begin
            state <= DONE;
          end
        end
        (state == ADDR): begin
          state <= DATA;
        end
        (state == DATA): begin
          bytes_loaded <= bytes_loaded + 1'b1;
          if (addr == LAST) begin
            state <= DONE;
          end else begin
            addr  <= addr + 1'b1;
            state <= WAIT_BYTE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore output decode from registered state
  always_comb begin
    in_ready  = 1'b0;
    bus_drive = 1'b0;
    mar_load  = 1'b0;
    ram_write = 1'b0;
    cpu_halt  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    bus_val   = '0;
    unique case (1'b1)
      (state == WAIT_BYTE): begin
        in_ready = 1'b1;
        cpu_halt = 1'b1;
        busy     = 1'b1;
      end
      (state == ADDR): begin
        bus_drive = 1'b1;
        mar_load  = 1'b1;
        cpu_halt  = 1'b1;
        busy      = 1'b1;
        bus_val   = DATA_WIDTH'(addr);
      end
      (state == DATA): begin
        bus_drive = 1'b1;
        ram_write = 1'b1;
        cpu_halt  = 1'b1;
        busy      = 1'b1;
        bus_val   = data_q;
      end
      (state == DONE): begin
        done     = 1'b1;
        cpu_halt = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        bus_val = '0;
      end
    endcase
  end

  assign bus_out = bus_drive ? bus_val : '0;

endmodule

// File: tb/tb_ram_program_loader.sv
// Self-checking bench for ram_program_loader.
// Scoreboard of expected RAM writes checked at the bus.
module tb_ram_program_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       finish = 1'b0;
  logic       manual_mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [7:0] bus_out;
  logic       bus_drive;
  logic       mar_load;
  logic       ram_write;
  logic       cpu_halt;
  logic       busy;
  logic       done;
  logic [4:0] bytes_loaded;

  ram_program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .manual_mode(manual_mode), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .bus_out(bus_out),
    .bus_drive(bus_drive), .mar_load(mar_load),
    .ram_write(ram_write), .cpu_halt(cpu_halt), .busy(busy),
    .done(done), .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        sb[$];
  wr_t        w;
  logic [7:0] ram_m [16];
  logic [3:0] mar_q = 4'h0;
  logic [3:0] exp_addr = 4'h0;
  logic       done_q = 1'b0;
  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Bus monitor, scoreboard checks and protocol checks
  always @(negedge clk) begin
    if (rst_n) begin
      compared++;
      if (mar_load && ram_write) begin
        mismatched++;
        $display("FAIL excl: mar_load=%b ram_write=%b both high", mar_load, ram_write);
      end
      compared++;
      if (bus_drive !== (mar_load | ram_write)) begin
        mismatched++;
        $display("FAIL bus_drive: got %b want %b", bus_drive, mar_load | ram_write);
      end
      compared++;
      if (busy && !cpu_halt) begin
        mismatched++;
        $display("FAIL halt: busy=1 but cpu_halt=%b", cpu_halt);
      end
      compared++;
      if (done && done_q) begin
        mismatched++;
        $display("FAIL done_pulse: done high %0d cycles, want 1", 2);
      end
      compared++;
      if (in_ready !== (busy && !bus_drive && !done)) begin
        mismatched++;
        $display("FAIL in_ready: got %b want %b", in_ready, busy && !bus_drive && !done);
      end
      if (mar_load) begin
        compared++;
        if (sb.size() == 0 || bus_out !== {4'h0, sb[0].a}) begin
          mismatched++;
          $display("FAIL mar_addr: got %h want %h", bus_out,
                   sb.size() ? {4'h0, sb[0].a} : 8'hxx);
        end
        mar_q = bus_out[3:0];
      end
      if (ram_write) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL ram_write: unexpected write got %h want none", bus_out);
        end else begin
          w = sb.pop_front();
          if (mar_q !== w.a || bus_out !== w.d) begin
            mismatched++;
            $display("FAIL ram_data: got [%h]=%h want [%h]=%h", mar_q, bus_out, w.a, w.d);
          end
        end
        ram_m[mar_q] = bus_out;
      end
      done_q = done;
    end else begin
      done_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load();
    start = 1'b1;
    exp_addr = 4'h0;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit keep);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{exp_addr, b});
        exp_addr = exp_addr + 4'h1;
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!keep) in_valid = 1'b0;
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL accept: byte %h got not-accepted want accepted", b);
    end
  endtask

  task automatic wait_done(input int bound);
    bit got;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL done_timeout: got no done want done within %0d", bound);
    end
  endtask

  task automatic test_reset();
    #12;
    compared++;
    if ({in_ready, bus_out, bus_drive, mar_load, ram_write, cpu_halt,
         busy, done, bytes_loaded} !== 20'h0) begin
      mismatched++;
      $display("FAIL reset_out: got busy=%b halt=%b rdy=%b bl=%0d want all 0",
               busy, cpu_halt, in_ready, bytes_loaded);
    end
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL idle: got busy=%b rdy=%b want 0 0", busy, in_ready);
    end
    tick();
  endtask

  task automatic test_full_load();
    int c0;
    c0 = cyc;
    begin_load();
    for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
    in_valid = 1'b0;
    wait_done(10);
    compared++;
    if (cyc - c0 != 49) begin
      mismatched++;
      $display("FAIL full_cycles: got %0d want 49", cyc - c0);
    end
    compared++;
    if (bytes_loaded !== 5'd16) begin
      mismatched++;
      $display("FAIL full_count: got %0d want 16", bytes_loaded);
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL full_sb: got %0d pending want 0", sb.size());
    end
    for (int i = 0; i < 16; i++) begin
      compared++;
      if (ram_m[i] !== 8'(i)) begin
        mismatched++;
        $display("FAIL full_ram%0d: got %h want %h", i, ram_m[i], 8'(i));
      end
    end
    tick();
  endtask

  task automatic test_early_finish();
    begin_load();
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hC3, 1'b0);
    finish = 1'b1;
    wait_done(20);
    finish = 1'b0;
    compared++;
    if (bytes_loaded !== 5'd3 || cpu_halt !== 1'b1) begin
      mismatched++;
      $display("FAIL early_count: got %0d halt=%b want 3 halt=1", bytes_loaded, cpu_halt);
    end
    @(negedge clk);
    compared++;
    if (cpu_halt !== 1'b0 || busy !== 1'b0 || bytes_loaded !== 5'd3) begin
      mismatched++;
      $display("FAIL early_release: got halt=%b busy=%b bl=%0d want 0 0 3",
               cpu_halt, busy, bytes_loaded);
    end
    compared++;
    if (ram_m[0] !== 8'hA1 || ram_m[1] !== 8'hB2 ||
        ram_m[2] !== 8'hC3 || ram_m[3] !== 8'h03) begin
      mismatched++;
      $display("FAIL early_ram: got %h %h %h %h want a1 b2 c3 03",
               ram_m[0], ram_m[1], ram_m[2], ram_m[3]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] v [5];
    for (int i = 0; i < 5; i++) v[i] = 8'($urandom_range(0, 255));
    begin_load();
    for (int i = 0; i < 5; i++) send(v[i], 1'b1);
    tick();
    in_valid = 1'b0;
    finish = 1'b1;
    wait_done(20);
    finish = 1'b0;
    compared++;
    if (bytes_loaded !== 5'd5) begin
      mismatched++;
      $display("FAIL bp_count: got %0d want 5", bytes_loaded);
    end
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (ram_m[i] !== v[i]) begin
        mismatched++;
        $display("FAIL bp_ram%0d: got %h want %h", i, ram_m[i], v[i]);
      end
    end
    tick();
  endtask

  task automatic test_collisions();
    manual_mode = 1'b1;
    start = 1'b1;
    tick();
    tick();
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL manual_start: got busy=%b want 0", busy);
    end
    tick();
    start = 1'b0;
    manual_mode = 1'b0;
    begin_load();
    finish = 1'b1;
    send(8'h55, 1'b0);
    tick();
    finish = 1'b0;
    tick();
    @(negedge clk);
    compared++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL finish_ignored: got busy=%b rdy=%b done=%b want 1 1 0",
               busy, in_ready, done);
    end
    tick();
    start = 1'b1;
    manual_mode = 1'b1;
    send(8'h66, 1'b0);
    start = 1'b0;
    manual_mode = 1'b0;
    finish = 1'b1;
    wait_done(20);
    finish = 1'b0;
    compared++;
    if (bytes_loaded !== 5'd2) begin
      mismatched++;
      $display("FAIL coll_count: got %0d want 2", bytes_loaded);
    end
    compared++;
    if (ram_m[0] !== 8'h55 || ram_m[1] !== 8'h66) begin
      mismatched++;
      $display("FAIL coll_ram: got %h %h want 55 66", ram_m[0], ram_m[1]);
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    bit got;
    got = 1'b0;
    begin_load();
    send(8'h77, 1'b0);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (ram_write) got = 1'b1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (!got || {in_ready, bus_out, bus_drive, mar_load, ram_write,
                 cpu_halt, busy, done, bytes_loaded} !== 20'h0) begin
      mismatched++;
      $display("FAIL reset_mid: got seen=%b busy=%b halt=%b wr=%b bl=%0d want 1 0 0 0 0",
               got, busy, cpu_halt, ram_write, bytes_loaded);
    end
    tick();
    rst_n = 1'b1;
    sb.delete();
    tick();
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || cpu_halt !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: got busy=%b halt=%b want 0 0", busy, cpu_halt);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram_m[i] = 8'h00;
    test_reset();
    test_full_load();
    test_early_finish();
    test_backpressure();
    test_collisions();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end want end by 200000");
    $fatal(1);
  end

endmodule
